// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
// Holds the FSM state encoding and the counter width rule.
package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A WIDTH of 1 would give $clog2 = 0, so the counter keeps at least one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one full-subtractor cell reused LSB-first,
// one bit per clock, with a start/ready handshake and a one-cycle done pulse.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_msb_d;
    logic [WIDTH-1:0] w_res_next;

    full_sub_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == LAST_CNT);

    // The new difference bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) bit has reached position 0; built without slicing so WIDTH=1 works.
    always_comb begin
        w_msb_d            = '0;
        w_msb_d[WIDTH-1]   = w_d;
        w_res_next         = (r_res >> 1) | w_msb_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    // Results are published on the edge into DONE so they are
                    // valid in the same cycle as the done pulse.
                    if (w_last) begin
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready      = (r_state == ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       ready1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .ready      (ready1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (bout1)
    );

    // Stimulus driver for one 8-bit operation; reports latency (-1 on timeout).
    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, output int lat,
                         output logic [7:0] od, output logic obo, output logic rdy_run);
        lat = -1; od = '0; obo = 1'b0; rdy_run = 1'b1;
        @(negedge clk);
        start = 1'b1; a = oa; b = ob;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                rdy_run = ready;
            end
            if (done) begin
                lat = k; od = diff; obo = borrow_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
        checks++; if (ready1 !== 1'b1 || done1 !== 1'b0 || diff1 !== 1'b0 || bout1 !== 1'b0) begin
            failures++; $display("FAIL reset_w1 got=%b%b%b%b exp=1000", ready1, done1, diff1, bout1);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [7:0] od; logic obo; logic rr;
        do_op(8'h5A, 8'h3C, lat, od, obo, rr);
        checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        checks++; if (rr !== 1'b0) begin failures++; $display("FAIL basic_ready_in_run got=%b exp=0", rr); end
        checks++; if (od !== 8'h1E) begin failures++; $display("FAIL basic_diff got=%h exp=1e", od); end
        checks++; if (obo !== 1'b0) begin failures++; $display("FAIL basic_borrow got=%b exp=0", obo); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_ready_return got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_single got=%b exp=0", done); end
        checks++; if (diff !== 8'h1E) begin failures++; $display("FAIL basic_diff_hold got=%h exp=1e", diff); end
    endtask

    task automatic test_underflow();
        int lat; logic [7:0] od; logic obo; logic rr;
        do_op(8'h00, 8'h01, lat, od, obo, rr);
        @(negedge clk);
        checks++; if (od !== 8'hFF || obo !== 1'b1) begin
            failures++; $display("FAIL underflow_0_1 got=%h/%b exp=ff/1", od, obo);
        end
        do_op(8'h80, 8'h80, lat, od, obo, rr);
        @(negedge clk);
        checks++; if (od !== 8'h00 || obo !== 1'b0) begin
            failures++; $display("FAIL equal_80_80 got=%h/%b exp=00/0", od, obo);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0; logic [7:0] od = '0; logic obo = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
            if (k == 4) start = 1'b0;
            if (done) begin ndone++; od = diff; obo = borrow_out; end
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
        checks++; if (od !== 8'h0F || obo !== 1'b0) begin
            failures++; $display("FAIL busy_result got=%h/%b exp=0f/0", od, obo);
        end
    endtask

    task automatic test_reset_midop();
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (diff !== 8'h00 || borrow_out !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got=%h/%b exp=00/0", diff, borrow_out);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_back_to_back();
        localparam int NOPS = 60;
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] fixa [6] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h80};
        logic [7:0] fixb [6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h7F};
        int nacc = 0, ndone = 0, last_acc = -1, last_done = -1;
        logic [7:0] ea, eb, exp_d;
        logic exp_b;
        for (int cyc = 0; cyc < NOPS * 10 + 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (qa.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_unexpected_done got=%h exp=none", diff);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front();
                    exp_d = 8'((int'(ea) - int'(eb) + 256) % 256);
                    exp_b = (ea < eb);
                    checks++; if (diff !== exp_d) begin
                        failures++; $display("FAIL b2b_diff a=%h b=%h got=%h exp=%h", ea, eb, diff, exp_d);
                    end
                    checks++; if (borrow_out !== exp_b) begin
                        failures++; $display("FAIL b2b_borrow a=%h b=%h got=%b exp=%b", ea, eb, borrow_out, exp_b);
                    end
                end
                if (last_done >= 0) begin
                    checks++; if (cyc - last_done != 10) begin
                        failures++; $display("FAIL b2b_done_spacing got=%0d exp=10", cyc - last_done);
                    end
                end
                last_done = cyc;
                ndone++;
                if (ndone == NOPS) break;
            end
            if (ready && nacc < NOPS) begin
                a = (nacc < 6) ? fixa[nacc] : 8'($urandom_range(0, 255));
                b = (nacc < 6) ? fixb[nacc] : 8'($urandom_range(0, 255));
                qa.push_back(a); qb.push_back(b);
                start = 1'b1;
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 10) begin
                        failures++; $display("FAIL b2b_accept_spacing got=%0d exp=10", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                nacc++;
            end else if (nacc == NOPS) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (ndone != NOPS) begin failures++; $display("FAIL b2b_done_total got=%0d exp=%0d", ndone, NOPS); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_width1();
        int lat;
        logic od, obo;
        int ia, ib;
        for (int i = 0; i < 4; i++) begin
            ia = i / 2; ib = i % 2;
            lat = -1; od = 1'b0; obo = 1'b0;
            @(negedge clk);
            start1 = 1'b1; a1 = 1'(ia); b1 = 1'(ib);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k == 1) start1 = 1'b0;
                if (done1) begin lat = k; od = diff1; obo = bout1; break; end
            end
            checks++; if (lat !== 2) begin failures++; $display("FAIL w1_latency a=%0d b=%0d got=%0d exp=2", ia, ib, lat); end
            checks++; if (od !== 1'((ia - ib + 2) % 2) || obo !== (ia < ib)) begin
                failures++; $display("FAIL w1_result a=%0d b=%0d got=%b/%b exp=%0d/%0d", ia, ib, od, obo, (ia - ib + 2) % 2, ia < ib);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtractor controller that computes an N-bit difference A − B by sequencing a single 1-bit full-subtractor cell LSB-first, one bit per clock. It accepts operands through a start/ready handshake, iterates the cell WIDTH times while carrying the borrow in a flop, and reports the result with a one-cycle done pulse. It sits beside the combinational arithmetic cells as the low-area alternative to a ripple-borrow array.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is 1 to 64.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only when ready=1.
- a  input  WIDTH  minuend; captured in the cycle start&ready=1.
- b  input  WIDTH  subtrahend; captured in the same cycle as a.
- ready  output  1  high only in IDLE; reset value 1.
- done  output  1  one-cycle pulse marking valid results; reset value 0.
- diff  output  WIDTH  registered A − B mod 2^WIDTH; reset value 0.
- borrow_out  output  1  final borrow; 1 means A < B unsigned. Reset value 0.

## Operation
- FSM states:
  - IDLE: ready=1. start=1 captures a and b into shift registers, clears the borrow flop and bit counter, and moves to RUN. start=0 stays in IDLE.
  - RUN: ready=0. Each cycle feeds the LSB of each shift register plus the borrow flop to the cell (d = a^b^bin, bout = ~a&b | ~a&bin | b&bin).
    - d is shifted into the MSB of the result shift register.
    - The borrow flop is updated to bout.
    - The operand registers shift right and the counter increments.
    - After the cycle with counter = WIDTH−1, go to DONE.
  - DONE: diff is loaded from the result shift register and borrow_out from the borrow flop, registered on entry. done=1 for this single cycle, then go to IDLE unconditionally.
- diff and borrow_out hold their last values until the next DONE. They are never updated mid-operation.
- start while ready=0 is ignored. It is not queued.
- Counter width is $clog2(WIDTH), with a minimum of 1 bit. For WIDTH=1, RUN lasts exactly one cycle.
- rst=1 in any state forces IDLE, clears the counter, borrow flop and shift registers, and sets the outputs to their reset values. Any operation in flight is abandoned and produces no done.

## Timing
- Cycle T: start=1, ready=1 → operands captured at the T edge. Cycles T+1 … T+WIDTH are RUN.
- Cycle T+WIDTH+1: DONE, with done=1 and diff and borrow_out valid.
- Cycle T+WIDTH+2: IDLE, ready=1. The earliest next accepted start is in this cycle.
- Latency is WIDTH+1 cycles from accept to done; throughput is one operation per WIDTH+2 cycles.
- ready is a registered state decode, not combinationally dependent on start.
- done never asserts in two consecutive cycles.

## Structure
- Shared package: state enum (IDLE, RUN, DONE), 2-bit encoding.
- One sub-module: full_sub_cell, a purely combinational 1-bit cell with inputs a, b, bin and outputs d, bout. It is instantiated once; the controller holds all state.
- The controller contains the FSM, counter, the two operand shift registers, the result shift register and the borrow flop.

## Test plan
- Basic: WIDTH=8, a=0x5A, b=0x3C → done in cycle T+9, diff=0x1E, borrow_out=0. ready returns in cycle T+10.
- Underflow: a=0x00, b=0x01 → diff=0xFF, borrow_out=1. Also a=0x80, b=0x80 → diff=0x00, borrow_out=0.
- Busy ignore: a=0x10, b=0x01 accepted. Pulse start with a=0xFF, b=0x00 during RUN → only one done, with diff=0x0F and borrow_out=0.
- Reset mid-op: assert rst at cycle T+4 of a=0x33, b=0x11 → next cycle ready=1, done=0, diff=0, borrow_out=0. No done follows.
- Back-to-back: start held high continuously → accepts every WIDTH+2 cycles, with done pulses exactly WIDTH+2 apart. A scoreboard checks all 256×256 pairs, or a random subset, against (a−b) mod 256 and (a<b).
- WIDTH=1: a=0, b=1 → done in cycle T+2, diff=1, borrow_out=1.
